// File: rtl/rpn_stack_pkg.sv
// Shared definitions for the RPN calculator: ALU opcodes, command and error encodings, FSM states.
// No logic; constants, types and two small decode helpers only.
// Imported by the stack sequencer and by the ALU so both agree on every code.
package rpn_stack_pkg;

  // ALU opcode field width and codes; any code above AC_RM is illegal.
  localparam int AC_N = 4;
  localparam logic [AC_N-1:0] AC_AD = 4'd0;  // A + B
  localparam logic [AC_N-1:0] AC_SB = 4'd1;  // A - B
  localparam logic [AC_N-1:0] AC_AN = 4'd2;  // A & B
  localparam logic [AC_N-1:0] AC_OR = 4'd3;  // A | B
  localparam logic [AC_N-1:0] AC_LS = 4'd4;  // signed A < B -> 1/0
  localparam logic [AC_N-1:0] AC_MU = 4'd5;  // low N bits of A * B
  localparam logic [AC_N-1:0] AC_DI = 4'd6;  // signed A / B, toward zero
  localparam logic [AC_N-1:0] AC_RM = 4'd7;  // signed A % B, sign of A

  // Front-end command encodings on in_op.
  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_EXEC = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;
  localparam logic [1:0] OP_CLR  = 2'd3;

  // Sticky error code values.
  localparam logic [2:0] ER_NONE = 3'd0;
  localparam logic [2:0] ER_OVF  = 3'd1;
  localparam logic [2:0] ER_UDF  = 3'd2;
  localparam logic [2:0] ER_DIV0 = 3'd3;
  localparam logic [2:0] ER_ILL  = 3'd4;

  // Sequencer states: idle/accepting, operand capture, write-back.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPS  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // True for opcodes the ALU implements.
  function automatic logic cmd_legal(input logic [AC_N-1:0] c);
    return (c <= AC_RM);
  endfunction

  // True for opcodes that divide by B.
  function automatic logic cmd_is_div(input logic [AC_N-1:0] c);
    return (c == AC_DI) || (c == AC_RM);
  endfunction

endpackage

// File: rtl/rpn_stack_alu.sv
// Combinational calculator ALU: C = A <cmd> B on N-bit signed operands.
// Zero latency; purely combinational.
// No handshake; the caller holds operands stable while C is consumed.
module rpn_stack_alu
  import rpn_stack_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [AC_N-1:0] cmd,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  output logic [N-1:0]    c
);

  // Result select; divide by zero returns 0 as a safe value (the sequencer never issues it).
  always_comb begin
    c = '0;
    case (cmd)
      AC_AD: c = a + b;
      AC_SB: c = a - b;
      AC_AN: c = a & b;
      AC_OR: c = a | b;
      AC_LS: c = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      AC_MU: c = a * b;
      AC_DI: if (b != '0) c = $signed(a) / $signed(b);
      AC_RM: if (b != '0) c = $signed(a) % $signed(b);
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack.sv
// Operand stack and sequencer feeding the ALU; PUSH/POP/CLR complete in 1 cycle.
// EXEC takes 3 cycles acceptance-to-acceptance (IDLE -> OPS -> WB); new top visible at t+3.
// in_ready is high only in IDLE; upstream holds its command while in_ready is low.
module rpn_stack
  import rpn_stack_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 8,
  parameter int DW    = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [N-1:0]    in_data,
  input  logic [AC_N-1:0] in_cmd,
  output logic [N-1:0]    top,
  output logic [DW-1:0]   depth,
  output logic [2:0]      err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);
  localparam logic [DW-1:0] TWO_W   = DW'(2);

  state_t            state, state_nxt;
  logic [N-1:0]      mem [DEPTH];
  logic [DW-1:0]     depth_q;
  logic [2:0]        err_q;
  logic [N-1:0]      op_a, op_b, alu_c, mem_top;
  logic [AC_N-1:0]   op_cmd;
  logic [AW-1:0]     idx_push, idx_top, idx_sec;

  logic              push_we, pop_en, clr_en, exec_go, ops_ld, wb_en;
  logic [2:0]        err_new;

  // Entry addresses; truncation is safe because each is only used when in range.
  assign idx_push = AW'(depth_q);
  assign idx_top  = AW'(depth_q - 1'b1);
  assign idx_sec  = AW'(depth_q - TWO_W);
  assign mem_top  = mem[idx_top];

  assign top      = (depth_q != '0) ? mem_top : '0;
  assign depth    = depth_q;
  assign err_code = err_q;

  // State register; reset mid-EXEC drops back to IDLE so WB never happens.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state, handshake and command decode; all checks use the pre-command stack.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    push_we   = 1'b0;
    pop_en    = 1'b0;
    clr_en    = 1'b0;
    exec_go   = 1'b0;
    ops_ld    = 1'b0;
    wb_en     = 1'b0;
    err_new   = ER_NONE;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (in_op)
            OP_PUSH: begin
              if (depth_q < DEPTH_W) push_we = 1'b1;
              else                   err_new = ER_OVF;
            end
            OP_POP: begin
              if (depth_q != '0) pop_en  = 1'b1;
              else               err_new = ER_UDF;
            end
            OP_CLR: clr_en = 1'b1;
            default: begin  // OP_EXEC
              if (depth_q < TWO_W)                           err_new = ER_UDF;
              else if (!cmd_legal(in_cmd))                   err_new = ER_ILL;
              else if (cmd_is_div(in_cmd) && mem_top == '0)  err_new = ER_DIV0;
              else begin
                exec_go   = 1'b1;
                state_nxt = ST_OPS;
              end
            end
          endcase
        end
      end
      ST_OPS: begin
        ops_ld    = 1'b1;
        state_nxt = ST_WB;
      end
      ST_WB: begin
        wb_en     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Depth and sticky error: CLR wipes both, otherwise only the first error is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
      err_q   <= ER_NONE;
    end else if (clr_en) begin
      depth_q <= '0;
      err_q   <= ER_NONE;
    end else begin
      if (push_we)         depth_q <= depth_q + 1'b1;
      else if (pop_en || wb_en) depth_q <= depth_q - 1'b1;
      if (err_q == ER_NONE && err_new != ER_NONE) err_q <= err_new;
    end
  end

  // Stack storage (not reset): PUSH writes above the top, WB overwrites the second entry.
  always_ff @(posedge clk) begin
    if (!rst && push_we) mem[idx_push] <= in_data;
    if (!rst && wb_en)   mem[idx_sec]  <= alu_c;
  end

  // Operand registers: opcode captured at acceptance, A/B captured in OPS for use in WB.
  always_ff @(posedge clk) begin
    if (exec_go) op_cmd <= in_cmd;
    if (ops_ld) begin
      op_a <= mem[idx_sec];
      op_b <= mem_top;
    end
  end

  rpn_stack_alu #(.N(N)) u_alu (
    .cmd (op_cmd),
    .a   (op_a),
    .b   (op_b),
    .c   (alu_c)
  );

endmodule

// File: tb/tb_rpn_stack.sv
// Directed bench for rpn_stack with hand-computed expected stack state.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
// Every comparison funnels through check(); the summary line reports the totals.
module tb_rpn_stack;
  import rpn_stack_pkg::*;

  localparam int N     = 16;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [N-1:0]    in_data;
  logic [AC_N-1:0] in_cmd;
  logic [N-1:0]    top;
  logic [DW-1:0]   depth;
  logic [2:0]      err_code;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rpn_stack #(.N(N), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_data  (in_data),
    .in_cmd   (in_cmd),
    .top      (top),
    .depth    (depth),
    .err_code (err_code)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_stack(input string tag, input int exp_depth, input int exp_top, input int exp_err);
    check({tag, ".depth"}, int'(depth), exp_depth);
    check({tag, ".top"}, $signed(top), exp_top);
    check({tag, ".err"}, int'(err_code), exp_err);
  endtask

  // Present one command for exactly one accepting edge; waits (bounded) for in_ready.
  task automatic send(input logic [1:0] op, input int data, input logic [AC_N-1:0] cmd);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) check("ready_timeout", int'(in_ready), 1);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data[N-1:0];
    in_cmd   = cmd;
    step();
    in_valid = 1'b0;
  endtask

  task automatic push(input int v);
    send(OP_PUSH, v, '0);
  endtask

  // EXEC then let OPS/WB run out so the next check sees the settled stack.
  task automatic exec_op(input logic [AC_N-1:0] cmd);
    send(OP_EXEC, 0, cmd);
    step();
    step();
  endtask

  initial begin
    logic [AC_N-1:0] bad_cmd;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_data = '0; in_cmd = '0;
    step();
    step();
    check_stack("reset", 0, 0, 0);
    check("reset.ready", int'(in_ready), 1);
    rst = 1'b0;

    // 1: 7 - 2 with ready timing through OPS and WB
    push(7);
    push(2);
    check_stack("push2", 2, 2, 0);
    send(OP_EXEC, 0, AC_SB);
    check("sb.ready_t1", int'(in_ready), 0);
    step();
    check("sb.ready_t2", int'(in_ready), 0);
    step();
    check("sb.ready_t3", int'(in_ready), 1);
    check_stack("sb", 1, 5, 0);

    // 2: signed divide/remainder truncate toward zero; multiply keeps low bits
    push(-3); push(2); exec_op(AC_DI);
    check_stack("di", 2, -1, 0);
    push(-7); push(2); exec_op(AC_RM);
    check_stack("rm", 3, -1, 0);
    push(300); push(300); exec_op(AC_MU);
    check_stack("mu", 4, 24464, 0);

    // 3: underflow on EXEC and POP, sticky first error
    send(OP_CLR, 0, '0);
    check_stack("clr1", 0, 0, 0);
    push(5); exec_op(AC_AD);
    check_stack("udf_exec", 1, 5, 2);
    send(OP_POP, 0, '0);
    send(OP_POP, 0, '0);
    check_stack("udf_pop", 0, 0, 2);

    // 4: divide by zero leaves the stack intact
    send(OP_CLR, 0, '0);
    push(9); push(0); exec_op(AC_RM);
    check_stack("div0", 2, 0, 3);
    send(OP_CLR, 0, '0);
    check_stack("clr2", 0, 0, 0);

    // 5: overflow at full depth, then an add on the full stack
    for (int i = 1; i <= DEPTH + 1; i++) push(i);
    check_stack("ovf", 8, 8, 1);
    exec_op(AC_AD);
    check_stack("ovf_add", 7, 15, 1);

    // Illegal opcode, then logic ops keep executing under the flagged error
    send(OP_CLR, 0, '0);
    push(1); push(2);
    bad_cmd = 4'hA;
    exec_op(bad_cmd);
    check_stack("ill", 2, 2, 4);
    exec_op(AC_LS);
    check_stack("ls", 1, 1, 4);
    push(12); push(10); exec_op(AC_AN);
    check_stack("an", 2, 8, 4);
    push(3); exec_op(AC_OR);
    check_stack("or", 2, 11, 4);

    // 6: reset during OPS aborts the EXEC
    send(OP_CLR, 0, '0);
    push(4); push(6);
    send(OP_EXEC, 0, AC_AD);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_stack("rst_ops", 0, 0, 0);
    check("rst_ops.ready", int'(in_ready), 1);

    // Commands offered while busy are ignored
    push(4); push(6);
    send(OP_EXEC, 0, AC_SB);
    in_valid = 1'b1; in_op = OP_PUSH; in_data = 16'd1;
    step();
    step();
    in_valid = 1'b0;
    check_stack("busy_push", 1, -2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rpn_stack.md
Name: rpn_stack

Overview:
- Operand stack and sequencer that sits directly upstream of the calculator ALU. It owns the value stack, accepts push/pop/execute commands from the keypad/control front end, and presents the two top entries to the combinational alu as A (second) and B (top).
- It writes the ALU result C back as the new top of stack.
- It detects overflow, underflow, divide-by-zero and illegal commands, and reports them on a sticky error code.

Parameters:
- N, 16, data width; must match the alu N.
- DEPTH, 8, number of stack entries; must be ≥2.
- DW, $clog2(DEPTH+1), width of the depth output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command this cycle.
- in_op  in  2  command: 0 PUSH, 1 EXEC, 2 POP, 3 CLR.
- in_data  in  N  signed value for PUSH.
- in_cmd  in  AC_N  ALU opcode for EXEC; uses the AC_* codes.
- top  out  N  current top of stack; 0 when empty.
- depth  out  DW  number of valid entries.
- err_code  out  3  0 none, 1 overflow, 2 underflow, 3 divide-by-zero, 4 illegal cmd.

Behaviour:
- Reset: rst high at a clock edge gives depth=0, top=0, err_code=0, in_ready=1, FSM=IDLE. Reset mid-EXEC aborts the operation with no write. Stack storage itself is not reset.
- Handshake: a command is accepted when in_valid && in_ready. When in_ready=0, in_valid is ignored and upstream holds the command.
- FSM states: IDLE, OPS, WB. in_ready=1 only in IDLE.
- PUSH, accepted in cycle t:
  - If depth<DEPTH: write in_data at mem[depth] and increment depth. top shows in_data from t+1.
  - Else: stack unchanged, overflow error.
- POP:
  - If depth≥1: decrement depth.
  - Else: underflow error.
  - Single cycle; remains in IDLE.
- CLR: sets depth=0 and err_code=0 in one cycle.
- EXEC, accepted in cycle t:
  - If depth<2: underflow error, stay in IDLE, stack unchanged.
  - If in_cmd is not one of AC_AD, AC_SB, AC_AN, AC_OR, AC_LS, AC_MU, AC_DI, AC_RM: illegal-cmd error, stack unchanged.
  - If in_cmd is AC_DI or AC_RM and mem[depth-1]==0: divide-by-zero error, stack unchanged, no ALU write.
  - Otherwise move to OPS:
    - t+1 (OPS): register A=mem[depth-2], B=mem[depth-1], cmd into operand registers that drive the alu; go to WB.
    - t+2 (WB): write alu C to mem[depth-2], decrement depth, return to IDLE.
    - in_ready is 0 during t+1 and t+2, high again at t+3. New top is visible from t+3.
  - Execute latency is therefore 3 cycles from acceptance to the next acceptance.
- Arithmetic: the alu is the arithmetic authority.
  - Results are truncated to N bits; MU keeps the low N bits.
  - DI/RM follow signed truncation toward zero, with the remainder taking the sign of A.
  - LS yields 1 or 0.
- Operand order: A is the older entry, B is the newer entry, so "push 7, push 2, SB" yields 5.
- Errors:
  - err_code captures the first error only; it is sticky until CLR or rst.
  - Later errors do not overwrite it.
  - Commands continue to execute normally while an error is flagged.
- top: mem[depth-1] when depth>0, else 0; combinational from registered state.

Decomposition:
- ALU_INTERFACE.v, the shared include, already holds AC_N and the AC_* opcodes; reuse it unchanged.
- Add to the same shared include:
  - the in_op encodings: OP_PUSH, OP_EXEC, OP_POP, OP_CLR;
  - the err_code encodings: ER_NONE, ER_OVF, ER_UDF, ER_DIV0, ER_ILL.
- One sub-module: an instance of the existing alu, with parameter N passed through. It is driven from the OPS operand registers, and its C output is consumed in WB.
- No other hierarchy.

Test Plan:
1. rst; PUSH 7; PUSH 2; EXEC AC_SB -> in_ready low for 2 cycles after acceptance, then top=5, depth=1, err_code=0.
2. PUSH -3; PUSH 2; EXEC AC_DI -> top=-1. PUSH -7; PUSH 2; EXEC AC_RM -> top=-1. PUSH 300; PUSH 300; EXEC AC_MU -> top=90000 mod 65536 = 24464.
3. After CLR, PUSH 5; EXEC AC_AD -> err_code=2, depth=1, top=5. Then POP; POP -> depth=0, err_code stays 2.
4. PUSH 9; PUSH 0; EXEC AC_RM -> err_code=3, depth=2, top=0. Then CLR -> err_code=0, depth=0.
5. PUSH DEPTH+1 values 1..9 -> depth=8, top=8, err_code=1. Then EXEC AC_AD -> top=15, depth=7.
6. Assert rst in the OPS cycle of an EXEC with stack [4,6] -> next cycle depth=0, top=0, in_ready=1. Also drive in_valid while in_ready=0 with PUSH 1 -> the PUSH is ignored (depth unchanged).
